// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, exception codes, FSM states.
package mem_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_LR   = 2'b11
  } memSize_e;

  typedef enum logic [1:0] {
    EXC_NONE = 2'b00,
    EXC_ADEL = 2'b01,
    EXC_ADES = 2'b10,
    EXC_BUS  = 2'b11
  } excCode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } lsuState_e;

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus port between the LSU (master) and memory (slave).
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);
  // Handshake: master raises bus_req_o with addr/we/wdata held stable; the slave
  // accepts by pulsing bus_ack_i for one cycle with bus_rdata_i valid on that cycle.
  logic              bus_req_o;
  logic [3:0]        bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [31:0]       bus_wdata_o;
  logic              bus_ack_i;
  logic [31:0]       bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering for stores and lane extraction for loads.
// LWL/LWR/SWL/SWR on mem type x11 are built only when UNALIGNED_LWLR_EN is defined.
module mem_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]  memType,
  input  logic [1:0]  offset,
  input  logic [31:0] storeData,
  input  logic [31:0] rdata,
  output logic [3:0]  byteEn,
  output logic [31:0] busWdata,
  output logic [31:0] loadData,
  output logic        misaligned
);

  logic [4:0]  shDn;
  logic [31:0] rdShifted;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  logic        signExt;

  // Lane n sits 8*(3-n) bits above bit 0; ~offset equals 3-offset for 2 bits.
  assign shDn      = {~offset, 3'b000};
  assign rdShifted = rdata >> shDn;
  assign laneByte  = rdShifted[7:0];
  assign laneHalf  = offset[1] ? rdata[15:0] : rdata[31:16];
  assign signExt   = memType[2];

`ifdef UNALIGNED_LWLR_EN
  logic [4:0] shUp;
  assign shUp = {offset, 3'b000};
`endif

  always_comb begin
    byteEn     = '0;
    busWdata   = '0;
    loadData   = '0;
    misaligned = 1'b0;
    case (memType[1:0])
      SZ_BYTE: begin
        byteEn   = 4'b1000 >> offset;
        busWdata = {4{storeData[7:0]}};
        loadData = {{24{signExt & laneByte[7]}}, laneByte};
      end
      SZ_HALF: begin
        byteEn     = offset[1] ? 4'b0011 : 4'b1100;
        busWdata   = {2{storeData[15:0]}};
        loadData   = {{16{signExt & laneHalf[15]}}, laneHalf};
        misaligned = offset[0];
      end
      SZ_WORD: begin
        byteEn     = 4'b1111;
        busWdata   = storeData;
        loadData   = rdata;
        misaligned = |offset;
      end
      SZ_LR: begin
`ifdef UNALIGNED_LWLR_EN
        // storeData doubles as the old rt value being merged into.
        if (!memType[2]) begin
          byteEn   = 4'b1111 >> offset;
          busWdata = storeData >> shUp;
          loadData = (rdata << shUp) | (storeData & ~(32'hFFFF_FFFF << shUp));
        end else begin
          byteEn   = 4'b1111 << ~offset;
          busWdata = storeData << shDn;
          loadData = (rdata >> shDn) | (storeData & ~(32'hFFFF_FFFF >> shDn));
        end
`else
        misaligned = 1'b1;
`endif
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: IDLE/BUSY/DONE sequencer with bus timeout and registered writeback.
// Optional LWL/LWR/SWL/SWR support is enabled with UNALIGNED_LWLR_EN.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int REG_ID_W = 7,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  input  logic                mem_read_i,
  input  logic                mem_write_i,
  input  logic                regwrite_i,
  input  logic [2:0]          mem_type_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [31:0]         wdata_i,
  input  logic [REG_ID_W-1:0] wreg_i,
  input  logic [31:0]         pc_i,
  output logic                stall_o,
  mem_lsu_if.master           bus,
  output logic                wb_valid_o,
  output logic                wb_regwrite_o,
  output logic [31:0]         wb_data_o,
  output logic [REG_ID_W-1:0] wb_reg_o,
  output logic [31:0]         wb_pc_o,
  output logic                exc_o,
  output logic [1:0]          exc_code_o,
  output logic [ADDR_W-1:0]   badvaddr_o,
  output lsuState_e           dbgState
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsuState_e      state;
  logic [CNT_W-1:0] count;
  logic [31:0]    capData;
  excCode_e       capExc;

  logic        isMem;
  logic        busy;
  logic        misaligned;
  logic [3:0]  byteEn;
  logic [31:0] busWdata;
  logic [31:0] loadData;

  mem_lane_align uAlign (
    .memType    (mem_type_i),
    .offset     (addr_i[1:0]),
    .storeData  (wdata_i),
    .rdata      (bus.bus_rdata_i),
    .byteEn     (byteEn),
    .busWdata   (busWdata),
    .loadData   (loadData),
    .misaligned (misaligned)
  );

  assign isMem    = mem_read_i | mem_write_i;
  assign busy     = (state == BUSY);
  assign dbgState = state;

  // Misaligned ops retire straight from IDLE, so they never stall.
  assign stall_o = !rst && (busy || (state == IDLE && valid_i && isMem && !misaligned));

  assign bus.bus_req_o   = busy;
  assign bus.bus_we_o    = (busy && mem_write_i) ? byteEn : 4'b0000;
  assign bus.bus_addr_o  = busy ? {addr_i[ADDR_W-1:2], 2'b00} : '0;
  assign bus.bus_wdata_o = (busy && mem_write_i) ? busWdata : 32'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      count         <= '0;
      capData       <= '0;
      capExc        <= EXC_NONE;
      wb_valid_o    <= 1'b0;
      wb_regwrite_o <= 1'b0;
      wb_data_o     <= '0;
      wb_reg_o      <= '0;
      wb_pc_o       <= '0;
      exc_o         <= 1'b0;
      exc_code_o    <= EXC_NONE;
      badvaddr_o    <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      exc_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            if (!isMem) begin
              wb_valid_o    <= 1'b1;
              wb_regwrite_o <= regwrite_i;
              wb_data_o     <= 32'(addr_i);
              wb_reg_o      <= wreg_i;
              wb_pc_o       <= pc_i;
              exc_code_o    <= EXC_NONE;
            end else if (misaligned) begin
              wb_valid_o    <= 1'b1;
              wb_regwrite_o <= 1'b0;
              wb_data_o     <= '0;
              wb_reg_o      <= wreg_i;
              wb_pc_o       <= pc_i;
              exc_o         <= 1'b1;
              exc_code_o    <= mem_write_i ? EXC_ADES : EXC_ADEL;
              badvaddr_o    <= addr_i;
            end else begin
              count <= '0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          // An ack on the final counted cycle still completes normally.
          if (bus.bus_ack_i) begin
            capData <= mem_write_i ? 32'h0 : loadData;
            capExc  <= EXC_NONE;
            state   <= DONE;
          end else if (count == CNT_LAST) begin
            capData <= '0;
            capExc  <= EXC_BUS;
            state   <= DONE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        DONE: begin
          wb_valid_o    <= 1'b1;
          wb_regwrite_o <= (capExc == EXC_NONE) && regwrite_i;
          wb_data_o     <= capData;
          wb_reg_o      <= wreg_i;
          wb_pc_o       <= pc_i;
          exc_o         <= (capExc != EXC_NONE);
          exc_code_o    <= capExc;
          if (capExc != EXC_NONE) badvaddr_o <= addr_i;
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu against a byte-array reference model.
// Exercises LWL/LWR/SWL/SWR when UNALIGNED_LWLR_EN is defined, reserved-type traps otherwise.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int REG_ID_W = 7;
  localparam int TIMEOUT  = 4;

  logic clk = 1'b0;
  logic rst;
  logic valid_i, mem_read_i, mem_write_i, regwrite_i;
  logic [2:0] mem_type_i;
  logic [ADDR_W-1:0] addr_i;
  logic [31:0] wdata_i, pc_i;
  logic [REG_ID_W-1:0] wreg_i;
  logic stall_o, wb_valid_o, wb_regwrite_o, exc_o;
  logic [31:0] wb_data_o, wb_pc_o;
  logic [REG_ID_W-1:0] wb_reg_o;
  logic [1:0] exc_code_o;
  logic [ADDR_W-1:0] badvaddr_o;
  lsuState_e dbgState;

  mem_lsu_if #(.ADDR_W(ADDR_W)) bus ();

  mem_lsu #(.ADDR_W(ADDR_W), .REG_ID_W(REG_ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .regwrite_i(regwrite_i), .mem_type_i(mem_type_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .wreg_i(wreg_i), .pc_i(pc_i),
    .stall_o(stall_o), .bus(bus), .wb_valid_o(wb_valid_o),
    .wb_regwrite_o(wb_regwrite_o), .wb_data_o(wb_data_o), .wb_reg_o(wb_reg_o),
    .wb_pc_o(wb_pc_o), .exc_o(exc_o), .exc_code_o(exc_code_o),
    .badvaddr_o(badvaddr_o), .dbgState(dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int nChecks = 0;
  int nPass   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic stall0, stallBusy, got;
    int cycles, reqCycles;
    logic [3:0] we;
    logic [31:0] baddr, bwdata;
    logic [REG_ID_W-1:0] drvReg;
    logic [31:0] drvPc;
    logic wbRegwrite, exc;
    logic [1:0] code;
    logic [31:0] wbData, bad;
    logic [REG_ID_W-1:0] wbReg;
    logic [31:0] wbPc;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic logic [31:0] modelLoad(logic [2:0] mt, logic [1:0] off,
                                            logic [31:0] rd, logic [31:0] rt);
    logic [7:0] m[4];
    logic [7:0] r[4];
    logic [15:0] h;
    int n = int'(off);
    for (int k = 0; k < 4; k++) begin
      m[k] = rd[31-8*k -: 8];
      r[k] = rt[31-8*k -: 8];
    end
    case (mt[1:0])
      2'b00: return mt[2] ? {{24{m[n][7]}}, m[n]} : {24'h0, m[n]};
      2'b01: begin
        h = {m[n & 2], m[(n & 2) + 1]};
        return mt[2] ? {{16{h[15]}}, h} : {16'h0, h};
      end
      2'b10: return rd;
      default: begin
        if (!mt[2]) for (int j = 0; j <= 3 - n; j++) r[j] = m[n + j];
        else        for (int j = 0; j <= n; j++)     r[3 - n + j] = m[j];
        return {r[0], r[1], r[2], r[3]};
      end
    endcase
  endfunction

  task automatic modelStore(input logic [2:0] mt, input logic [1:0] off,
                            input logic [31:0] wd, output logic [3:0] we,
                            output logic [31:0] data);
    logic [7:0] w[4];
    logic [7:0] d[4];
    int n = int'(off);
    we = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      w[k] = wd[31-8*k -: 8];
      d[k] = 8'h00;
    end
    case (mt[1:0])
      2'b00: begin we[3-n] = 1'b1; for (int k = 0; k < 4; k++) d[k] = w[3]; end
      2'b01: begin
        we[3-n] = 1'b1; we[2-n] = 1'b1;
        for (int k = 0; k < 4; k++) d[k] = w[2 + (k % 2)];
      end
      2'b10: begin we = 4'b1111; for (int k = 0; k < 4; k++) d[k] = w[k]; end
      default: begin
        if (!mt[2]) for (int k = n; k < 4; k++) begin we[3-k] = 1'b1; d[k] = w[k-n]; end
        else        for (int k = 0; k <= n; k++) begin we[3-k] = 1'b1; d[k] = w[3-n+k]; end
      end
    endcase
    data = {d[0], d[1], d[2], d[3]};
  endtask

  // ---------------- driver ----------------
  // Presents one op at a negedge, plays memory with the given ack delay
  // (-1 = never ack) and returns what was observed; ends on a negedge.
  task automatic runOp(input logic rd, input logic wr, input logic rw,
                       input logic [2:0] mt, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rdata,
                       input int ackDelay, output obs_t o);
    o = '{default: 0};
    o.stallBusy = 1'b1;
    o.drvReg = REG_ID_W'($urandom_range(0, 127));
    o.drvPc  = $urandom;
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr; regwrite_i = rw;
    mem_type_i = mt; addr_i = addr; wdata_i = wd; wreg_i = o.drvReg; pc_i = o.drvPc;
    bus.bus_rdata_i = rdata;
    #1 o.stall0 = stall_o;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (wb_valid_o) begin
        o.got = 1'b1; o.cycles = c;
        o.wbRegwrite = wb_regwrite_o; o.wbData = wb_data_o; o.wbReg = wb_reg_o;
        o.wbPc = wb_pc_o; o.exc = exc_o; o.code = exc_code_o; o.bad = badvaddr_o;
        break;
      end
      if (bus.bus_req_o) begin
        o.reqCycles++;
        o.we = bus.bus_we_o; o.baddr = bus.bus_addr_o; o.bwdata = bus.bus_wdata_o;
        o.stallBusy = o.stallBusy & stall_o;
      end
      bus.bus_ack_i = bus.bus_req_o && ackDelay >= 0 && o.reqCycles > ackDelay;
    end
    bus.bus_ack_i = 1'b0;
    valid_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; regwrite_i = 1'b0;
    mem_type_i = 3'b000; addr_i = '0; wdata_i = '0; wreg_i = '0; pc_i = '0;
    bus.bus_ack_i = 1'b0; bus.bus_rdata_i = '0;
    repeat (2) @(negedge clk);
    nChecks++; if (bus.bus_req_o !== 1'b0) $display("FAIL reset_req got=%b exp=0", bus.bus_req_o); else nPass++;
    nChecks++; if (wb_valid_o !== 1'b0) $display("FAIL reset_wbvalid got=%b exp=0", wb_valid_o); else nPass++;
    nChecks++; if ({wb_data_o, wb_pc_o, exc_o, exc_code_o} !== '0) $display("FAIL reset_wb got=%h/%h/%b/%b exp=0", wb_data_o, wb_pc_o, exc_o, exc_code_o); else nPass++;
    nChecks++; if (dbgState !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbgState, IDLE); else nPass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu();
    obs_t o;
    logic [31:0] a;
    logic rw;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; rw = 1'($urandom_range(0, 1));
      runOp(1'b0, 1'b0, rw, 3'($urandom_range(0, 7)), a, $urandom, $urandom, 0, o);
      nChecks++; if (o.stall0 !== 1'b0) $display("FAIL alu_stall got=%b exp=0", o.stall0); else nPass++;
      nChecks++; if (o.cycles != 1) $display("FAIL alu_latency got=%0d exp=1", o.cycles); else nPass++;
      nChecks++; if (o.wbData !== a) $display("FAIL alu_data got=%h exp=%h", o.wbData, a); else nPass++;
      nChecks++; if ({o.wbRegwrite, o.wbReg, o.wbPc, o.exc} !== {rw, o.drvReg, o.drvPc, 1'b0})
        $display("FAIL alu_fields got=%b/%h/%h/%b exp=%b/%h/%h/0", o.wbRegwrite, o.wbReg, o.wbPc, o.exc, rw, o.drvReg, o.drvPc); else nPass++;
    end
    @(posedge clk); @(negedge clk);
    nChecks++; if (wb_valid_o !== 1'b0) $display("FAIL alu_pulse got=%b exp=0", wb_valid_o); else nPass++;
  endtask

  task automatic test_vectors();
    obs_t o;
    runOp(1'b1, 1'b0, 1'b1, 3'b100, 32'h1003, 32'h0, 32'h0000_00F0, 2, o);
    nChecks++; if (o.wbData !== 32'hFFFF_FFF0) $display("FAIL lb_signed got=%h exp=FFFFFFF0", o.wbData); else nPass++;
    nChecks++; if ({o.wbRegwrite, o.exc} !== 2'b10) $display("FAIL lb_flags got=%b%b exp=10", o.wbRegwrite, o.exc); else nPass++;
    nChecks++; if (o.cycles != 5) $display("FAIL lb_latency got=%0d exp=5", o.cycles); else nPass++;
    nChecks++; if ({o.we, o.baddr} !== {4'b0000, 32'h1000}) $display("FAIL lb_bus got=%b/%h exp=0000/00001000", o.we, o.baddr); else nPass++;
    runOp(1'b0, 1'b1, 1'b0, 3'b001, 32'h2002, 32'h0000_ABCD, $urandom, 0, o);
    nChecks++; if ({o.we, o.bwdata, o.baddr} !== {4'b0011, 32'hABCD_ABCD, 32'h2000})
      $display("FAIL sh_bus got=%b/%h/%h exp=0011/ABCDABCD/00002000", o.we, o.bwdata, o.baddr); else nPass++;
    nChecks++; if (o.stallBusy !== 1'b1 || o.stall0 !== 1'b1) $display("FAIL sh_stall got=%b%b exp=11", o.stall0, o.stallBusy); else nPass++;
    runOp(1'b1, 1'b0, 1'b1, 3'b010, 32'h3001, 32'h0, $urandom, 0, o);
    nChecks++; if (o.reqCycles != 0 || o.stall0 !== 1'b0) $display("FAIL lw_mis_bus got=req%0d/stall%b exp=req0/stall0", o.reqCycles, o.stall0); else nPass++;
    nChecks++; if ({o.exc, o.code, o.bad, o.wbRegwrite} !== {1'b1, 2'b01, 32'h3001, 1'b0})
      $display("FAIL lw_mis_exc got=%b/%b/%h/%b exp=1/01/00003001/0", o.exc, o.code, o.bad, o.wbRegwrite); else nPass++;
    nChecks++; if (o.cycles != 1) $display("FAIL lw_mis_latency got=%0d exp=1", o.cycles); else nPass++;
  endtask

  task automatic test_timeout();
    obs_t o;
    logic [31:0] r;
    runOp(1'b1, 1'b0, 1'b1, 3'b010, 32'h4000, 32'h0, $urandom, -1, o);
    nChecks++; if (o.got !== 1'b1) $display("FAIL to_retire got=%b exp=1", o.got); else nPass++;
    nChecks++; if ({o.exc, o.code, o.bad, o.wbRegwrite} !== {1'b1, 2'b11, 32'h4000, 1'b0})
      $display("FAIL to_exc got=%b/%b/%h/%b exp=1/11/00004000/0", o.exc, o.code, o.bad, o.wbRegwrite); else nPass++;
    nChecks++; if (o.reqCycles != TIMEOUT || o.cycles != TIMEOUT + 2)
      $display("FAIL to_cycles got=req%0d/ret%0d exp=req%0d/ret%0d", o.reqCycles, o.cycles, TIMEOUT, TIMEOUT + 2); else nPass++;
    nChecks++; if (bus.bus_req_o !== 1'b0) $display("FAIL to_req_drop got=%b exp=0", bus.bus_req_o); else nPass++;
    bus.bus_ack_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk);
      nChecks++; if ({wb_valid_o, bus.bus_req_o} !== 2'b00) $display("FAIL late_ack got=%b%b exp=00", wb_valid_o, bus.bus_req_o); else nPass++;
    end
    bus.bus_ack_i = 1'b0;
    r = $urandom;
    runOp(1'b1, 1'b0, 1'b1, 3'b010, 32'h4004, 32'h0, r, 1, o);
    nChecks++; if ({o.wbData, o.exc, o.wbRegwrite} !== {r, 1'b0, 1'b1}) $display("FAIL to_next got=%h/%b/%b exp=%h/0/1", o.wbData, o.exc, o.wbRegwrite, r); else nPass++;
    nChecks++; if (o.cycles != 4) $display("FAIL to_next_latency got=%0d exp=4", o.cycles); else nPass++;
  endtask

  task automatic test_reset_busy();
    obs_t o;
    logic [31:0] r;
    runOp(1'b0, 1'b0, 1'b1, 3'b000, 32'h5A5A_5A5A, 32'h0, 32'h0, 0, o);
    valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; regwrite_i = 1'b1;
    mem_type_i = 3'b010; addr_i = 32'h6000;
    @(posedge clk); @(negedge clk);
    nChecks++; if (bus.bus_req_o !== 1'b1) $display("FAIL rb_busy got=%b exp=1", bus.bus_req_o); else nPass++;
    rst = 1'b1;
    #1;
    nChecks++; if ({bus.bus_req_o, stall_o} !== 2'b00) $display("FAIL rb_req_drop got=%b%b exp=00", bus.bus_req_o, stall_o); else nPass++;
    nChecks++; if ({wb_valid_o, wb_regwrite_o, wb_data_o, wb_reg_o, wb_pc_o} !== '0)
      $display("FAIL rb_wb got=%b/%b/%h/%h/%h exp=0", wb_valid_o, wb_regwrite_o, wb_data_o, wb_reg_o, wb_pc_o); else nPass++;
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    r = $urandom;
    runOp(1'b1, 1'b0, 1'b1, 3'b010, 32'h6000, 32'h0, r, 0, o);
    nChecks++; if (o.cycles != 3 || o.wbData !== r) $display("FAIL rb_next got=%0d/%h exp=3/%h", o.cycles, o.wbData, r); else nPass++;
  endtask

  task automatic test_random_mem();
    obs_t o;
    logic [2:0] mt;
    logic [1:0] off;
    logic [31:0] a, wd, rdv, expD;
    logic [3:0] expWe;
    logic wr, rw;
    int d;
    for (int i = 0; i < 16; i++) begin
      mt = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
      off = (mt[1:0] == 2'b00) ? 2'($urandom_range(0, 3)) :
            (mt[1:0] == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
      a = ($urandom & 32'hFFFF_FFFC) | 32'(off);
      wr = 1'($urandom_range(0, 1)); rw = ~wr;
      wd = $urandom; rdv = $urandom; d = $urandom_range(0, 3);
      runOp(~wr, wr, rw, mt, a, wd, rdv, d, o);
      modelStore(mt, off, wd, expWe, expD);
      nChecks++; if (o.stall0 !== 1'b1 || o.cycles != 3 + d) $display("FAIL rnd_timing got=%b/%0d exp=1/%0d", o.stall0, o.cycles, 3 + d); else nPass++;
      nChecks++; if (o.baddr !== (a & 32'hFFFF_FFFC)) $display("FAIL rnd_addr got=%h exp=%h", o.baddr, a & 32'hFFFF_FFFC); else nPass++;
      if (wr) begin
        nChecks++; if ({o.we, o.bwdata} !== {expWe, expD}) $display("FAIL rnd_store got=%b/%h exp=%b/%h", o.we, o.bwdata, expWe, expD); else nPass++;
      end else begin
        expD = modelLoad(mt, off, rdv, wd);
        nChecks++; if ({o.we, o.wbData} !== {4'b0000, expD}) $display("FAIL rnd_load got=%b/%h exp=0000/%h", o.we, o.wbData, expD); else nPass++;
      end
      nChecks++; if ({o.wbRegwrite, o.exc, o.wbReg} !== {rw, 1'b0, o.drvReg}) $display("FAIL rnd_wb got=%b/%b/%h exp=%b/0/%h", o.wbRegwrite, o.exc, o.wbReg, rw, o.drvReg); else nPass++;
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    logic [31:0] a, rdv, got;
    int kind;
    for (int i = 0; i < 8; i++) begin
      kind = $urandom_range(0, 2);
      a = $urandom; rdv = $urandom;
      if (kind == 0) begin
        exp_q.push_back(a);
        runOp(1'b0, 1'b0, 1'b1, 3'b010, a, 32'h0, rdv, 0, o);
      end else if (kind == 1) begin
        a = a & 32'hFFFF_FFFC;
        exp_q.push_back(rdv);
        runOp(1'b1, 1'b0, 1'b1, 3'b010, a, 32'h0, rdv, 0, o);
      end else begin
        a = a | 32'h1;
        runOp(1'b0, 1'b1, 1'b0, 3'b001, a, 32'h0, rdv, 0, o);
        nChecks++; if ({o.exc, o.code, o.bad} !== {1'b1, 2'b10, a}) $display("FAIL b2b_ades got=%b/%b/%h exp=1/10/%h", o.exc, o.code, o.bad, a); else nPass++;
        continue;
      end
      got = o.wbData;
      nChecks++; if (exp_q.size() == 0 || got !== exp_q[0]) $display("FAIL b2b_data got=%h exp=%h", got, (exp_q.size() != 0) ? exp_q[0] : 32'h0); else nPass++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      nChecks++; if (o.cycles != ((kind == 0) ? 1 : 3)) $display("FAIL b2b_latency got=%0d exp=%0d", o.cycles, (kind == 0) ? 1 : 3); else nPass++;
    end
  endtask

`ifdef UNALIGNED_LWLR_EN
  task automatic test_lwlr();
    obs_t o;
    logic [2:0] mt;
    logic [1:0] off;
    logic [31:0] a, wd, rdv, expD;
    logic [3:0] expWe;
    logic wr;
    int d;
    runOp(1'b1, 1'b0, 1'b1, 3'b011, 32'h0000_0001, 32'hAABB_CCDD, 32'h1122_3344, 0, o);
    nChecks++; if (o.wbData !== 32'h2233_44DD) $display("FAIL lwl_vector got=%h exp=223344DD", o.wbData); else nPass++;
    nChecks++; if ({o.stall0, o.exc, o.wbRegwrite} !== 3'b101) $display("FAIL lwl_flags got=%b%b%b exp=101", o.stall0, o.exc, o.wbRegwrite); else nPass++;
    for (int i = 0; i < 10; i++) begin
      mt = {1'($urandom_range(0, 1)), 2'b11};
      off = 2'($urandom_range(0, 3));
      a = ($urandom & 32'hFFFF_FFFC) | 32'(off);
      wr = 1'($urandom_range(0, 1)); wd = $urandom; rdv = $urandom; d = $urandom_range(0, 2);
      runOp(~wr, wr, ~wr, mt, a, wd, rdv, d, o);
      modelStore(mt, off, wd, expWe, expD);
      if (wr) begin
        nChecks++; if ({o.we, o.bwdata} !== {expWe, expD}) $display("FAIL lr_store got=%b/%h exp=%b/%h", o.we, o.bwdata, expWe, expD); else nPass++;
      end else begin
        expD = modelLoad(mt, off, rdv, wd);
        nChecks++; if (o.wbData !== expD) $display("FAIL lr_load got=%h exp=%h", o.wbData, expD); else nPass++;
      end
      nChecks++; if (o.exc !== 1'b0 || o.cycles != 3 + d) $display("FAIL lr_retire got=%b/%0d exp=0/%0d", o.exc, o.cycles, 3 + d); else nPass++;
    end
  endtask
`else
  task automatic test_reserved_type();
    obs_t o;
    runOp(1'b1, 1'b0, 1'b1, 3'b011, 32'h0000_0040, 32'h0, $urandom, 0, o);
    nChecks++; if ({o.reqCycles != 0, o.exc, o.code, o.wbRegwrite} !== {1'b0, 1'b1, 2'b01, 1'b0})
      $display("FAIL rsv_load got=req%0d/%b/%b/%b exp=req0/1/01/0", o.reqCycles, o.exc, o.code, o.wbRegwrite); else nPass++;
    runOp(1'b0, 1'b1, 1'b0, 3'b111, 32'h0000_0044, 32'h0, $urandom, 0, o);
    nChecks++; if ({o.reqCycles != 0, o.exc, o.code, o.bad} !== {1'b0, 1'b1, 2'b10, 32'h44})
      $display("FAIL rsv_store got=req%0d/%b/%b/%h exp=req0/1/10/00000044", o.reqCycles, o.exc, o.code, o.bad); else nPass++;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_alu();
    test_vectors();
    test_timeout();
    test_reset_busy();
    test_random_mem();
    test_back_to_back();
`ifdef UNALIGNED_LWLR_EN
    test_lwlr();
`else
    test_reserved_type();
`endif
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
